// File: rtl/display_pkg.sv
// Shared display-path types and the default palette.
// rgb_t is a packed {R,G,B} triple; default_mask gives the channels lit per default entry.
package display_pkg;

  localparam int COLOR_WIDTH = 8;
  localparam int RGB_WIDTH   = 3 * COLOR_WIDTH;

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] r;
    logic [COLOR_WIDTH-1:0] g;
    logic [COLOR_WIDTH-1:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '{r: '0, g: '0, b: '0};
  localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};
  localparam rgb_t RED   = '{r: '1, g: '0, b: '0};
  localparam rgb_t GREEN = '{r: '0, g: '1, b: '0};
  localparam rgb_t BLUE  = '{r: '0, g: '0, b: '1};

  // {R,G,B} channel-on bits of the default entry; lets any
  // channel width expand the same palette.
  function automatic logic [2:0] default_mask(input int idx);
    logic [2:0] m;
    m = 3'b000;
    unique case (idx)
      1:       m = 3'b111;
      2:       m = 3'b100;
      3:       m = 3'b010;
      4:       m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/palette_bank.sv
// One palette bank: ENTRIES x 3*COLOR_WIDTH register file, async read.
// Ports: clk_i, rst_i (async high), we_i/waddr_i/wdata_i write, raddr_i/rdata_o read.
module palette_bank
  import display_pkg::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int COLOR_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [INDEX_WIDTH-1:0]   waddr_i,
  input  logic [3*COLOR_WIDTH-1:0] wdata_i,
  input  logic [INDEX_WIDTH-1:0]   raddr_i,
  output logic [3*COLOR_WIDTH-1:0] rdata_o
);

  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam int EW      = 3 * COLOR_WIDTH;

  logic [EW-1:0] mem_q [ENTRIES];

  function automatic logic [EW-1:0] dflt(input int idx);
    logic [2:0]    m;
    logic [EW-1:0] e;
    m = default_mask(idx);
    e = '0;
    for (int c = 0; c < 3; c++)
      e[c*COLOR_WIDTH +: COLOR_WIDTH] = {COLOR_WIDTH{m[c]}};
    return e;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++)
        mem_q[i] <= dflt(i);
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/palette_lut.sv
// Index -> RGB lookup with double-buffered palette and 2-stage valid/ready pipe.
// Ports: host write/commit, frame start, index stream in, colour stream out.
module palette_lut
  import display_pkg::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int COLOR_WIDTH = 8
) (
  input  logic                     aClock,
  input  logic                     aReset,
  input  logic                     aWriteEnable,
  input  logic [INDEX_WIDTH-1:0]   aWriteAddress,
  input  logic [3*COLOR_WIDTH-1:0] aWriteData,
  input  logic                     aCommit,
  input  logic                     aFrameStart,
  output logic                     anCommitPending,
  output logic                     anActiveBank,
  input  logic                     aInValid,
  input  logic [INDEX_WIDTH-1:0]   aInIndex,
  output logic                     anInReady,
  output logic                     anOutValid,
  input  logic                     anOutReady,
  output logic [COLOR_WIDTH-1:0]   anOutRed,
  output logic [COLOR_WIDTH-1:0]   anOutGreen,
  output logic [COLOR_WIDTH-1:0]   anOutBlue
);

  localparam int EW = 3 * COLOR_WIDTH;

  typedef enum logic {IDLE, PENDING} swap_t;

  swap_t state_q, state_d;
  logic  bank_q, bank_d;

  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  // A frame start in the commit cycle itself is too early:
  // the swap waits for the next one.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE:
        if (aCommit) state_d = PENDING;
      PENDING:
        if (aFrameStart) begin
          state_d = IDLE;
          bank_d  = ~bank_q;
        end
      default: state_d = IDLE;
    endcase
  end

  assign anCommitPending = (state_q == PENDING);
  assign anActiveBank    = bank_q;

  logic [INDEX_WIDTH-1:0] idx1_q;
  logic                   v1_q, bsel1_q, v2_q;
  logic [EW-1:0]          rgb2_q, rd0, rd1, rd;
  logic                   en1, en2;

  // Writes go to the pre-edge shadow bank.
  palette_bank #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .COLOR_WIDTH (COLOR_WIDTH)
  ) u_bank0 (
    .clk_i   (aClock),
    .rst_i   (aReset),
    .we_i    (aWriteEnable & bank_q),
    .waddr_i (aWriteAddress),
    .wdata_i (aWriteData),
    .raddr_i (idx1_q),
    .rdata_o (rd0)
  );

  palette_bank #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .COLOR_WIDTH (COLOR_WIDTH)
  ) u_bank1 (
    .clk_i   (aClock),
    .rst_i   (aReset),
    .we_i    (aWriteEnable & ~bank_q),
    .waddr_i (aWriteAddress),
    .wdata_i (aWriteData),
    .raddr_i (idx1_q),
    .rdata_o (rd1)
  );

  assign rd  = bsel1_q ? rd1 : rd0;
  assign en2 = ~v2_q | anOutReady;
  assign en1 = ~v1_q | en2;

  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      v1_q    <= 1'b0;
      idx1_q  <= '0;
      bsel1_q <= 1'b0;
    end else if (en1) begin
      v1_q    <= aInValid;
      idx1_q  <= aInIndex;
      bsel1_q <= bank_q;
    end
  end

  // Colour only reloads on a real pixel; a bubble just drops valid.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      v2_q   <= 1'b0;
      rgb2_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) rgb2_q <= rd;
    end
  end

  assign anInReady  = en1;
  assign anOutValid = v2_q;
  assign anOutRed   = rgb2_q[2*COLOR_WIDTH +: COLOR_WIDTH];
  assign anOutGreen = rgb2_q[COLOR_WIDTH +: COLOR_WIDTH];
  assign anOutBlue  = rgb2_q[0 +: COLOR_WIDTH];

endmodule
